// File: rtl/hdmi_clk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hdmi_clk_pkg                                                    |
// | Purpose  : Shared state encodings and timing defaults for the HDMI         |
// |            PLL reset sequencer.                                            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package hdmi_clk_pkg;

    localparam logic [2:0] c_st_pll_rst   = 3'd0;
    localparam logic [2:0] c_st_wait_lock = 3'd1;
    localparam logic [2:0] c_st_stable    = 3'd2;
    localparam logic [2:0] c_st_run       = 3'd3;
    localparam logic [2:0] c_st_fail      = 3'd4;

    localparam int c_loss_w      = 8;
    localparam int c_retry_w_min = 3;

    // Defaults sized for the 27 MHz reference clock
    localparam int c_rst_cycles    = 16;
    localparam int c_lock_timeout  = 27000;
    localparam int c_stable_cycles = 2700;
    localparam int c_max_retries   = 4;

    function automatic int max3_int(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync_2ff                                                        |
// | Purpose  : Generic 1-bit two-flop synchroniser with async reset to 0.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/pll_reset_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pll_reset_seq                                                   |
// | Purpose  : rPLL power-up / lock supervisor; releases downstream reset      |
// |            only after a qualified stable lock. Optional retry limit        |
// |            with FAIL state enabled by macro PLL_RETRY_LIMIT_EN.            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pll_reset_seq
    import hdmi_clk_pkg::*;
#(
    parameter int RST_CYCLES    = c_rst_cycles,
    parameter int LOCK_TIMEOUT  = c_lock_timeout,
    parameter int STABLE_CYCLES = c_stable_cycles,
    parameter int MAX_RETRIES   = c_max_retries
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pll_lock,
    input  logic                restart,
    output logic                pll_reset,
    output logic                rst_out,
    output logic                ready,
    output logic [2:0]          state_o,
    output logic [c_loss_w-1:0] loss_cnt,
    output logic                fail
);

    localparam int c_cnt_max = max3_int(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    // Retry width covers MAX_RETRIES but never drops below the 3-bit debug counter
    localparam int c_retry_need = $clog2(MAX_RETRIES + 1);
    localparam int c_retry_w    = (c_retry_need > c_retry_w_min) ? c_retry_need : c_retry_w_min;

    localparam logic [c_cnt_w-1:0] c_rst_last = c_cnt_w'(RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_stb_last = c_cnt_w'(STABLE_CYCLES - 1);

    logic                 w_lock_s;
    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_retry_w-1:0] r_retry;
    logic [c_retry_w-1:0] w_retry_nxt;
    logic [c_loss_w-1:0]  r_loss;
    logic [c_loss_w-1:0]  w_loss_nxt;
    logic                 r_pll_reset;
    logic                 r_rst_out;
    logic                 r_ready;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (reset),
        .i_d (pll_lock),
        .o_q (w_lock_s)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        w_loss_nxt  = r_loss;
        case (r_state)
            c_st_pll_rst: begin
                if (r_cnt == c_rst_last) begin
                    w_state_nxt = c_st_wait_lock;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            c_st_wait_lock: begin
                if (restart) begin
                    w_state_nxt = c_st_pll_rst;
                    w_cnt_nxt   = '0;
                end else if (w_lock_s) begin
                    w_state_nxt = c_st_stable;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_tmo_last) begin
                    w_cnt_nxt   = '0;
                    w_retry_nxt = (&r_retry) ? r_retry : r_retry + c_retry_w'(1);
`ifdef PLL_RETRY_LIMIT_EN
                    // This timeout is attempt number r_retry+1
                    if (r_retry >= c_retry_w'(MAX_RETRIES - 1)) begin
                        w_state_nxt = c_st_fail;
                    end else begin
                        w_state_nxt = c_st_pll_rst;
                    end
`else
                    w_state_nxt = c_st_pll_rst;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            c_st_stable: begin
                if (restart) begin
                    w_state_nxt = c_st_pll_rst;
                    w_cnt_nxt   = '0;
                end else if (!w_lock_s) begin
                    w_state_nxt = c_st_wait_lock;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_stb_last) begin
                    w_state_nxt = c_st_run;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            c_st_run: begin
                w_retry_nxt = '0;
                if (!w_lock_s && !(&r_loss)) begin
                    w_loss_nxt = r_loss + c_loss_w'(1);
                end
                if (restart || !w_lock_s) begin
                    w_state_nxt = c_st_pll_rst;
                    w_cnt_nxt   = '0;
                end
            end
`ifdef PLL_RETRY_LIMIT_EN
            c_st_fail: begin
                if (restart) begin
                    w_state_nxt = c_st_pll_rst;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = '0;
                end
            end
`endif
            default: begin
                w_state_nxt = c_st_pll_rst;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_pll_rst;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_loss      <= '0;
            r_pll_reset <= 1'b1;
            r_rst_out   <= 1'b1;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_loss      <= w_loss_nxt;
            r_pll_reset <= (w_state_nxt == c_st_pll_rst) || (w_state_nxt == c_st_fail);
            r_rst_out   <= (w_state_nxt != c_st_run);
            r_ready     <= (w_state_nxt == c_st_run);
        end
    end

`ifdef PLL_RETRY_LIMIT_EN
    logic r_fail;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fail <= 1'b0;
        end else begin
            r_fail <= (w_state_nxt == c_st_fail);
        end
    end

    assign fail = r_fail;
`else
    assign fail = 1'b0;
`endif

    assign pll_reset = r_pll_reset;
    assign rst_out   = r_rst_out;
    assign ready     = r_ready;
    assign state_o   = r_state;
    assign loss_cnt  = r_loss;

endmodule
`default_nettype wire
